// File: rtl/line_buffer_3row.sv
// line_buffer_3row: turns a raster pixel stream into vertical 3-pixel columns
// (top = row r-1, mid = row r, bot = row r+1) for a downstream 3x3 window stage.
// Zero rows pad the top and bottom of the frame, and a zero column follows
// every output row so the window can drain before the next row starts.
// Optional feature: define LB_ERR_EN to add the sticky err_o flag. This flag
// records any pixel offered while ready_o was low.
module line_buffer_3row #(
  parameter int ROWS   = 5,
  parameter int COLS   = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pix_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic [DATA_W-1:0] top_o,
  output logic [DATA_W-1:0] mid_o,
  output logic [DATA_W-1:0] bot_o,
  output logic              col_valid_o,
  output logic              win_valid_o,
  output logic              frame_done_o
`ifdef LB_ERR_EN
  ,
  output logic              err_o
`endif
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = $clog2(ROWS + 2);

  localparam logic [CW-1:0] COL_LAST    = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_ONE     = RW'(1);
  localparam logic [RW-1:0] ROW_IN_DONE = RW'(ROWS);
  localparam logic [RW-1:0] ROW_FLUSHED = RW'(ROWS + 1);

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    STREAM,
    FLUSH_COL,
    FLUSH_ROW,
    DONE
  } state_t;

  state_t state_q, state_d;
  logic [CW-1:0] col_cnt_q, col_cnt_d;
  logic [RW-1:0] row_cnt_q, row_cnt_d;
  logic          ready_q, ready_d;
  logic          col_vld_q, col_vld_d;
  logic          col_first_q, col_first_d;
  logic          win_vld_q;
  logic          done_q, done_d;
  logic [DATA_W-1:0] top_q, top_d;
  logic [DATA_W-1:0] mid_q, mid_d;
  logic [DATA_W-1:0] bot_q, bot_d;
`ifdef LB_ERR_EN
  logic          err_q;
`endif

  // Line storage is deliberately left unreset: FILL rewrites lb_mid before
  // any read, and lb_top is masked to zero on output row 0.
  logic [DATA_W-1:0] lb_top_q [COLS];
  logic [DATA_W-1:0] lb_mid_q [COLS];

  logic accept;
  logic col_last;

  assign accept   = valid_i && ready_q;
  assign col_last = (col_cnt_q == COL_LAST);

  // Next-state, counter and output-column selection
  always_comb begin
    state_d     = state_q;
    col_cnt_d   = col_cnt_q;
    row_cnt_d   = row_cnt_q;
    col_vld_d   = 1'b0;
    col_first_d = 1'b0;
    done_d      = 1'b0;
    top_d       = '0;
    mid_d       = '0;
    bot_d       = '0;
    case (state_q)
      IDLE, FILL: begin
        if (accept) begin
          if (col_last) begin
            col_cnt_d = '0;
            row_cnt_d = row_cnt_q + RW'(1);
            state_d   = STREAM;
          end else begin
            col_cnt_d = col_cnt_q + CW'(1);
            state_d   = FILL;
          end
        end
      end
      STREAM: begin
        if (accept) begin
          col_vld_d   = 1'b1;
          col_first_d = (col_cnt_q == '0);
          top_d       = (row_cnt_q == ROW_ONE) ? '0 : lb_top_q[col_cnt_q];
          mid_d       = lb_mid_q[col_cnt_q];
          bot_d       = pix_i;
          if (col_last) begin
            col_cnt_d = '0;
            row_cnt_d = row_cnt_q + RW'(1);
            state_d   = FLUSH_COL;
          end else begin
            col_cnt_d = col_cnt_q + CW'(1);
          end
        end
      end
      FLUSH_COL: begin
        // Zero column closes the current output row.
        col_vld_d = 1'b1;
        if (row_cnt_q == ROW_IN_DONE) begin
          state_d = FLUSH_ROW;
        end else if (row_cnt_q == ROW_FLUSHED) begin
          state_d = DONE;
        end else begin
          state_d = STREAM;
        end
      end
      FLUSH_ROW: begin
        // Last output row: bottom neighbour is the zero pad row.
        col_vld_d   = 1'b1;
        col_first_d = (col_cnt_q == '0);
        top_d       = lb_top_q[col_cnt_q];
        mid_d       = lb_mid_q[col_cnt_q];
        if (col_last) begin
          col_cnt_d = '0;
          row_cnt_d = row_cnt_q + RW'(1);
          state_d   = FLUSH_COL;
        end else begin
          col_cnt_d = col_cnt_q + CW'(1);
        end
      end
      DONE: begin
        done_d    = 1'b1;
        col_cnt_d = '0;
        row_cnt_d = '0;
        state_d   = IDLE;
      end
      default: begin
        state_d   = IDLE;
        col_cnt_d = '0;
        row_cnt_d = '0;
      end
    endcase
    ready_d = (state_d == IDLE) || (state_d == FILL) || (state_d == STREAM);
  end

  // FSM state, counters and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      col_cnt_q   <= '0;
      row_cnt_q   <= '0;
      ready_q     <= 1'b0;
      col_vld_q   <= 1'b0;
      col_first_q <= 1'b0;
      win_vld_q   <= 1'b0;
      done_q      <= 1'b0;
      top_q       <= '0;
      mid_q       <= '0;
      bot_q       <= '0;
    end else begin
      state_q     <= state_d;
      col_cnt_q   <= col_cnt_d;
      row_cnt_q   <= row_cnt_d;
      ready_q     <= ready_d;
      col_vld_q   <= col_vld_d;
      col_first_q <= col_first_d;
      win_vld_q   <= col_vld_q && !col_first_q;
      done_q      <= done_d;
      top_q       <= top_d;
      mid_q       <= mid_d;
      bot_q       <= bot_d;
    end
  end

  // Line arrays: each streamed pixel shifts its column up by one row
  always_ff @(posedge clk) begin
    if (accept) begin
      if (state_q == STREAM) begin
        lb_top_q[col_cnt_q] <= lb_mid_q[col_cnt_q];
      end
      lb_mid_q[col_cnt_q] <= pix_i;
    end
  end

`ifdef LB_ERR_EN
  // Sticky flag for pixels offered while the block was not ready
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (valid_i && !ready_q) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`endif

  assign ready_o      = ready_q;
  assign top_o        = top_q;
  assign mid_o        = mid_q;
  assign bot_o        = bot_q;
  assign col_valid_o  = col_vld_q;
  assign win_valid_o  = win_vld_q;
  assign frame_done_o = done_q;

endmodule

// File: tb/tb_line_buffer_3row.sv
// Bench for line_buffer_3row: a 3x3 and a 5x5 instance share clock and reset.
// Expected columns come from a frame-level model (zero-padded vertical
// neighbours plus a zero column per row), checked every cycle.
module tb_line_buffer_3row;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] pix [2];
  logic       vld [2];
  logic       rdy [2];
  logic [7:0] top [2];
  logic [7:0] mid [2];
  logic [7:0] bot [2];
  logic       cv  [2];
  logic       wv  [2];
  logic       fd  [2];
`ifdef LB_ERR_EN
  logic       err [2];
`endif

  line_buffer_3row #(.ROWS(3), .COLS(3)) u3 (
    .clk(clk), .rst(rst), .pix_i(pix[0]), .valid_i(vld[0]), .ready_o(rdy[0]),
    .top_o(top[0]), .mid_o(mid[0]), .bot_o(bot[0]), .col_valid_o(cv[0]),
    .win_valid_o(wv[0]), .frame_done_o(fd[0])
`ifdef LB_ERR_EN
    , .err_o(err[0])
`endif
  );

  line_buffer_3row #(.ROWS(5), .COLS(5)) u5 (
    .clk(clk), .rst(rst), .pix_i(pix[1]), .valid_i(vld[1]), .ready_o(rdy[1]),
    .top_o(top[1]), .mid_o(mid[1]), .bot_o(bot[1]), .col_valid_o(cv[1]),
    .win_valid_o(wv[1]), .frame_done_o(fd[1])
`ifdef LB_ERR_EN
    , .err_o(err[1])
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [23:0] q0 [$];
  logic [23:0] q1 [$];
  logic [23:0] cap [$];
  logic [23:0] lit [12];
  bit          capturing = 1'b0;
  logic [7:0]  img [5][5];

  int ncol [2];
  int nacc [2];
  bit pcol [2];
  bit pfirst [2];
  bit pstream [2];
  int wcnt [2];
  int ccnt [2];
  int fcnt [2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int dim(input int d);
    return (d == 0) ? 3 : 5;
  endfunction

  // Model: every output row r gives COLS columns of (img[r-1], img[r], img[r+1])
  // with out-of-frame rows as zero, then one all-zero column.
  task automatic push_frame(input int d);
    int n;
    logic [23:0] e;
    n = dim(d);
    for (int r = 0; r < n; r++) begin
      for (int c = 0; c < n; c++) begin
        e = {(r > 0) ? img[r-1][c] : 8'd0, img[r][c], (r < n - 1) ? img[r+1][c] : 8'd0};
        if (d == 0) q0.push_back(e); else q1.push_back(e);
      end
      if (d == 0) q0.push_back(24'h0); else q1.push_back(24'h0);
    end
  endtask

  // Per-cycle comparison of both instances against the model
  always @(negedge clk) begin : cmp
    for (int d = 0; d < 2; d++) begin
      int n;
      int qs;
      logic [23:0] e;
      n = dim(d);
      if (!rst) begin
        check("reset_outputs_zero",
              int'(rdy[d] | cv[d] | wv[d] | fd[d] | (|top[d]) | (|mid[d]) | (|bot[d])
`ifdef LB_ERR_EN
                   | err[d]
`endif
              ), 0);
        ncol[d] = 0; nacc[d] = 0; pcol[d] = 0; pfirst[d] = 0; pstream[d] = 0;
      end else begin
        check("win_valid", int'(wv[d]), int'(pcol[d] && !pfirst[d]));
        if (pstream[d]) check("col_latency", int'(cv[d]), 1);
        pcol[d] = cv[d];
        pfirst[d] = 1'b0;
        if (cv[d]) begin
          ccnt[d]++;
          qs = (d == 0) ? q0.size() : q1.size();
          if (qs == 0) begin
            check("col_unexpected", 1, 0);
          end else begin
            e = (d == 0) ? q0.pop_front() : q1.pop_front();
            check("col_top", int'(top[d]), int'(e[23:16]));
            check("col_mid", int'(mid[d]), int'(e[15:8]));
            check("col_bot", int'(bot[d]), int'(e[7:0]));
          end
          pfirst[d] = ((ncol[d] % (n + 1)) == 0);
          ncol[d]++;
          if (d == 0 && capturing) cap.push_back({top[d], mid[d], bot[d]});
        end
        if (wv[d]) wcnt[d]++;
        if (fd[d]) begin
          fcnt[d]++;
          check("frame_done_after_all_cols", ncol[d] % (n * (n + 1)), 0);
        end
        pstream[d] = vld[d] && rdy[d] && ((nacc[d] % (n * n)) >= n);
        if (vld[d] && rdy[d]) nacc[d]++;
      end
    end
  end

  task automatic send(input int d, input logic [7:0] p, input bit gaps,
                      output int acc, output int waits);
    bit ok;
    if (gaps) begin
      while ($urandom_range(0, 1) == 1) begin
        vld[d] = 1'b0;
        @(posedge clk); #1;
      end
    end
    pix[d] = p;
    vld[d] = 1'b1;
    waits = 0;
    ok = 1'b0;
    while (!ok && waits < 200) begin
      @(negedge clk);
      ok = rdy[d];
      @(posedge clk); #1;
      waits++;
    end
    acc = cyc;
    vld[d] = 1'b0;
    if (!ok) check("send_timeout", 0, 1);
  endtask

  task automatic clear_counts(input int d);
    wcnt[d] = 0; ccnt[d] = 0; fcnt[d] = 0;
  endtask

  task automatic finish_frame(input int d);
    int w;
    w = 0;
    while (fcnt[d] == 0 && w < 300) begin
      @(posedge clk); #1;
      w++;
    end
    repeat (4) @(posedge clk);
    #1;
    check("frame_done_pulses", fcnt[d], 1);
    check("model_queue_drained", (d == 0) ? q0.size() : q1.size(), 0);
  endtask

  task automatic run_frame(input int d, input bit gaps);
    int a, w, n;
    n = dim(d);
    clear_counts(d);
    push_frame(d);
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++)
        send(d, img[r][c], gaps, a, w);
    finish_frame(d);
    check("win_valid_count", wcnt[d], n * n);
    check("col_valid_count", ccnt[d], n * (n + 1));
  endtask

  task automatic check_cap(input string tag);
    check({tag, "_col_count"}, cap.size(), 12);
    for (int i = 0; i < 12 && i < cap.size(); i++)
      check({tag, "_literal_col"}, int'(cap[i]), int'(lit[i]));
  endtask

  task automatic load_3x3_ramp();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        img[r][c] = 8'(r * 3 + c + 1);
  endtask

  initial begin
    int a, w, a6;
    lit = '{24'h000104, 24'h000205, 24'h000306, 24'h000000,
            24'h010407, 24'h020508, 24'h030609, 24'h000000,
            24'h040700, 24'h050800, 24'h060900, 24'h000000};
    for (int d = 0; d < 2; d++) begin
      vld[d] = 1'b0; pix[d] = 8'h0; clear_counts(d);
    end
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready_low", int'(rdy[0]), 0);
    check("reset_col_valid_low", int'(cv[1]), 0);
    rst = 1'b1;
    @(negedge clk);
    check("ready_low_before_first_clk", int'(rdy[0]), 0);
    @(posedge clk); #1;
    check("ready_high_after_first_clk", int'(rdy[0]), 1);
    check("ready_high_after_first_clk_5x5", int'(rdy[1]), 1);

    // 3x3 ramp, back-to-back, with row-boundary ready timing
    load_3x3_ramp();
    clear_counts(0);
    push_frame(0);
    cap.delete();
    capturing = 1'b1;
    a6 = 0;
    for (int k = 1; k <= 9; k++) begin
      send(0, 8'(k), 1'b0, a, w);
      if (k == 6) begin
        a6 = a;
        check("ready_low_after_row_end", int'(rdy[0]), 0);
      end
      if (k == 7) begin
        check("pix7_accept_cycle_delta", a - a6, 2);
        check("pix7_wait_cycles", w, 2);
      end
    end
    finish_frame(0);
    capturing = 1'b0;
    check_cap("ramp3");
    check("ramp3_win_count", wcnt[0], 9);
    check("ramp3_col_count", ccnt[0], 12);
`ifdef LB_ERR_EN
    check("err_set_on_dropped_pixel", int'(err[0]), 1);
`endif

    // 5x5 ramp, gap-free then with random gaps
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        img[r][c] = 8'(r * 5 + c + 1);
    run_frame(1, 1'b0);
    run_frame(1, 1'b1);

    // 5x5 random pixels with gaps, and a random 3x3 frame
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        img[r][c] = 8'($urandom_range(0, 255));
    run_frame(1, 1'b1);
    run_frame(0, 1'b1);
`ifdef LB_ERR_EN
    check("err_sticky", int'(err[0]), 1);
`endif

    // Reset in the middle of row 2, then a fresh ramp frame
    load_3x3_ramp();
    push_frame(0);
    for (int k = 1; k <= 8; k++) send(0, 8'(k), 1'b0, a, w);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("midframe_reset_col_valid", int'(cv[0]), 0);
    check("midframe_reset_ready", int'(rdy[0]), 0);
    q0.delete();
    q1.delete();
    rst = 1'b1;
    @(negedge clk);
    check("ready_low_after_midframe_release", int'(rdy[0]), 0);
    @(posedge clk); #1;
    check("ready_high_after_midframe_release", int'(rdy[0]), 1);
    clear_counts(0);
    push_frame(0);
    cap.delete();
    capturing = 1'b1;
    for (int k = 1; k <= 9; k++) send(0, 8'(k), 1'b0, a, w);
    finish_frame(0);
    capturing = 1'b0;
    check_cap("after_reset");
    check("after_reset_win_count", wcnt[0], 9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
